// File: rtl/core_cycle_timer.sv
// core_cycle_timer
//   Core-memory cycle timer for the PDP-6 memory module model. Edge-detects
//   the start and wr_go request levels, then sequences a read half-cycle and
//   a write/restore half-cycle, each a fixed number of clock ticks long.
//
// Ports
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   start    cycle request level (rising edge starts a cycle)
//   rmw      read-modify-write select, latched when a cycle starts
//   wr_go    resume level for an RMW pause (rising edge resumes)
//   busy     high whenever a cycle is in progress
//   rd_l     read-current level
//   strobe   sense-strobe pulse, one clock
//   rd_done  read-restart pulse on the last read tick
//   wr_l     write/inhibit level
//   cyc_done cycle-complete pulse on the last write tick
//   ovr      a start edge arrived while a cycle was in progress
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no cycle; waiting for a start edge
// RD    | read half-cycle, cnt counts ticks 1..RD_TICKS
// PAUSE | RMW hold after the read; cnt held at 0, waits for a wr_go edge
// WR    | write/restore half-cycle, cnt counts ticks 1..WR_TICKS

module core_cycle_timer #(
  parameter int RD_TICKS    = 102,
  parameter int WR_TICKS    = 102,
  parameter int STROBE_TICK = 60,
  parameter int CW          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic rmw,
  input  logic wr_go,
  output logic busy,
  output logic rd_l,
  output logic strobe,
  output logic rd_done,
  output logic wr_l,
  output logic cyc_done,
  output logic ovr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] WR    = 2'd3;

  localparam logic [CW-1:0] RD_LAST  = CW'(RD_TICKS);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_TICKS);
  localparam logic [CW-1:0] STB_TICK = CW'(STROBE_TICK);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rmw_q, rmw_nxt;
  logic [1:0]    start_hist, wr_go_hist;
  logic          start_edge, wr_go_edge;

  // History resets to 0, so a level already high at reset release
  // produces exactly one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_hist <= 2'b00;
      wr_go_hist <= 2'b00;
    end else begin
      start_hist <= {start_hist[0], start};
      wr_go_hist <= {wr_go_hist[0], wr_go};
    end
  end

  assign start_edge = start_hist[0] & ~start_hist[1];
  assign wr_go_edge = wr_go_hist[0] & ~wr_go_hist[1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rmw_nxt   = rmw_q;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = RD;
          cnt_nxt   = ONE;
          rmw_nxt   = rmw;
        end
      end
      RD: begin
        if (cnt == RD_LAST) begin
          if (rmw_q) begin
            state_nxt = PAUSE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WR;
            cnt_nxt   = ONE;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      PAUSE: begin
        cnt_nxt = '0;
        if (wr_go_edge) begin
          state_nxt = WR;
          cnt_nxt   = ONE;
        end
      end
      default: begin
        if (cnt == WR_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      rmw_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rmw_q <= rmw_nxt;
    end
  end

  assign busy     = (state != IDLE);
  assign rd_l     = (state == RD);
  assign wr_l     = (state == WR);
  assign strobe   = (state == RD) && (cnt == STB_TICK);
  assign rd_done  = (state == RD) && (cnt == RD_LAST);
  assign cyc_done = (state == WR) && (cnt == WR_LAST);
  // Built from the registered edge history, never from the raw input.
  assign ovr      = start_edge && (state != IDLE);

endmodule

// File: tb/tb_core_cycle_timer.sv
module tb_core_cycle_timer;

  localparam int R = 102;
  localparam int W = 102;
  localparam int S = 60;

  localparam int K_BUSY_R = 0;
  localparam int K_RD_R   = 1;
  localparam int K_RD_F   = 2;
  localparam int K_WR_R   = 3;
  localparam int K_STROBE = 4;
  localparam int K_RDDONE = 5;
  localparam int K_CYCDN  = 6;
  localparam int K_OVR    = 7;
  localparam int K_WR_F   = 8;
  localparam int K_BUSY_F = 9;

  logic clk = 1'b0;
  logic reset, start, rmw, wr_go;
  logic busy, rd_l, strobe, rd_done, wr_l, cyc_done, ovr;

  int edge_n = 0;
  int n_checks = 0;
  int n_pass = 0;
  int overlap = 0;

  typedef struct {
    int kind;
    int edge_at;
  } ev_t;

  ev_t exp_q[$];

  core_cycle_timer #(
    .RD_TICKS(R), .WR_TICKS(W), .STROBE_TICK(S), .CW(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rmw(rmw), .wr_go(wr_go),
    .busy(busy), .rd_l(rd_l), .strobe(strobe), .rd_done(rd_done),
    .wr_l(wr_l), .cyc_done(cyc_done), .ovr(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic string kname(int k);
    case (k)
      K_BUSY_R: return "busy_rise";
      K_RD_R:   return "rd_l_rise";
      K_RD_F:   return "rd_l_fall";
      K_WR_R:   return "wr_l_rise";
      K_STROBE: return "strobe";
      K_RDDONE: return "rd_done";
      K_CYCDN:  return "cyc_done";
      K_OVR:    return "ovr";
      K_WR_F:   return "wr_l_fall";
      default:  return "busy_fall";
    endcase
  endfunction

  task automatic push(input int k, input int e);
    ev_t ev;
    ev.kind = k;
    ev.edge_at = e;
    exp_q.push_back(ev);
  endtask

  task automatic push_cycle(input int k);
    push(K_BUSY_R, k + 1);
    push(K_RD_R,   k + 1);
    push(K_STROBE, k + S);
    push(K_RDDONE, k + R);
    push(K_RD_F,   k + R + 1);
    push(K_WR_R,   k + R + 1);
    push(K_CYCDN,  k + R + W);
    push(K_WR_F,   k + R + W + 1);
    push(K_BUSY_F, k + R + W + 1);
  endtask

  // Match an observed output event against the expected set.
  task automatic note(input int k);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (idx < 0 && exp_q[i].kind == k && exp_q[i].edge_at == edge_n) idx = i;
    end
    n_checks++;
    if (idx >= 0) begin
      exp_q.delete(idx);
      n_pass++;
    end else begin
      $display("FAIL event %s: seen at edge %0d, expected at no such edge", kname(k), edge_n);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, want);
  endtask

  task automatic to_edge(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: outputs sampled mid-cycle, attributed to the preceding edge.
  logic p_busy = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  always @(negedge clk) begin
    if (busy && !p_busy) note(K_BUSY_R);
    if (rd_l && !p_rd)   note(K_RD_R);
    if (!rd_l && p_rd)   note(K_RD_F);
    if (wr_l && !p_wr)   note(K_WR_R);
    if (strobe)          note(K_STROBE);
    if (rd_done)         note(K_RDDONE);
    if (cyc_done)        note(K_CYCDN);
    if (ovr)             note(K_OVR);
    if (!wr_l && p_wr)   note(K_WR_F);
    if (!busy && p_busy) note(K_BUSY_F);
    if (rd_l && wr_l) overlap++;
    p_busy = busy;
    p_rd   = rd_l;
    p_wr   = wr_l;
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; rmw = 1'b0; wr_go = 1'b0;
    #1 reset = 1'b0; start = 1'b1;

    // Reset held with start high; release after edge 5 -> first sample edge 6.
    to_edge(3);
    check("reset_outputs_zero",
          {25'b0, busy, rd_l, strobe, rd_done, wr_l, cyc_done, ovr}, 32'd0);
    push_cycle(6);
    to_edge(5);  reset = 1'b1;
    to_edge(220); start = 1'b0;

    // Plain cycle
    push_cycle(230);
    to_edge(229); start = 1'b1;
    to_edge(240); start = 1'b0;

    // Stray wr_go in IDLE, RD and WR
    push_cycle(450);
    to_edge(445); wr_go = 1'b1;
    to_edge(447); wr_go = 1'b0;
    to_edge(449); start = 1'b1;
    to_edge(460); start = 1'b0;
    to_edge(470); wr_go = 1'b1;
    to_edge(480); wr_go = 1'b0;
    to_edge(600); wr_go = 1'b1;
    to_edge(610); wr_go = 1'b0;

    // Overrun during RD
    push_cycle(700);
    push(K_OVR, 721);
    to_edge(699); start = 1'b1;
    to_edge(710); start = 1'b0;
    to_edge(720); start = 1'b1;
    to_edge(730); start = 1'b0;

    // Start held high for 500 clocks
    push_cycle(920);
    to_edge(919);  start = 1'b1;
    to_edge(1420); start = 1'b0;

    // Start edge coincident with cyc_done
    push_cycle(1440);
    push(K_OVR, 1644);
    to_edge(1439); start = 1'b1;
    to_edge(1450); start = 1'b0;
    to_edge(1643); start = 1'b1;
    to_edge(1660); start = 1'b0;

    // RMW with a 50-clock pause; wr_go first sampled at edge 1833
    push(K_BUSY_R, 1681);
    push(K_RD_R,   1681);
    push(K_STROBE, 1740);
    push(K_RDDONE, 1782);
    push(K_RD_F,   1783);
    push(K_WR_R,   1834);
    push(K_CYCDN,  1935);
    push(K_WR_F,   1936);
    push(K_BUSY_F, 1936);
    to_edge(1679); rmw = 1'b1; start = 1'b1;
    to_edge(1690); start = 1'b0;
    to_edge(1700); rmw = 1'b0;
    to_edge(1810);
    check("pause_busy", {31'b0, busy}, 32'd1);
    check("pause_rd_l", {31'b0, rd_l}, 32'd0);
    check("pause_wr_l", {31'b0, wr_l}, 32'd0);
    to_edge(1832); wr_go = 1'b1;
    to_edge(1850); wr_go = 1'b0;

    // Reset at WR tick 40 (edge 2102)
    push(K_BUSY_R, 1961);
    push(K_RD_R,   1961);
    push(K_STROBE, 2020);
    push(K_RDDONE, 2062);
    push(K_RD_F,   2063);
    push(K_WR_R,   2063);
    push(K_WR_F,   2102);
    push(K_BUSY_F, 2102);
    to_edge(1959); start = 1'b1;
    to_edge(1970); start = 1'b0;
    to_edge(2102); reset = 1'b0;
    #1;
    check("reset_midwr_wr_l", {31'b0, wr_l}, 32'd0);
    check("reset_midwr_busy", {31'b0, busy}, 32'd0);
    to_edge(2110); reset = 1'b1;
    to_edge(2300);
    check("idle_after_release", {31'b0, busy}, 32'd0);

    to_edge(2320);
    check("rd_wr_overlap", overlap, 32'd0);
    while (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL event %s: not seen, expected at edge %0d",
               kname(exp_q[0].kind), exp_q[0].edge_at);
      exp_q.delete(0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
